// File: rtl/clk_div_detector.sv
// clk_div_detector
//   Monitors a divided clock produced by the ripple divider, measures its
//   period in clk_in cycles, decodes the period back to the divider code k
//   (period = 2^(k+1)) and reports lock once the ratio is stable.
//
// Ports
//   clk_in      in   reference clock, all logic on its rising edge
//   rstn        in   asynchronous active-low reset
//   clk_div_in  in   divided clock under measurement (asynchronous)
//   div_code    out  [DIV_WIDTH-1:0] decoded k of the locked period
//   period      out  [DIV_WIDTH+1:0] candidate period in clk_in cycles
//   locked      out  ratio stable
//   err         out  one-cycle pulse on loss of lock
module clk_div_detector #(
  parameter int DIV_WIDTH  = 2,
  parameter int LOCK_COUNT = 4
) (
  input  logic                 clk_in,
  input  logic                 rstn,
  input  logic                 clk_div_in,
  output logic [DIV_WIDTH-1:0] div_code,
  output logic [DIV_WIDTH+1:0] period,
  output logic                 locked,
  output logic                 err
);

  localparam int CNT_W   = DIV_WIDTH + 2;
  localparam int MATCH_W = $clog2(LOCK_COUNT);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  // A period is legal only if it is exactly 2^(k+1) for a supported k;
  // the saturated count is never a power of two, so it is never legal.
  function automatic logic is_legal(input logic [CNT_W-1:0] p);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < DIV_WIDTH; k++)
      if (p == (CNT_W'(1) << (k + 1))) ok = 1'b1;
    return ok;
  endfunction

  function automatic logic [DIV_WIDTH-1:0] code_of(input logic [CNT_W-1:0] p);
    logic [DIV_WIDTH-1:0] c;
    c = '0;
    for (int k = 0; k < DIV_WIDTH; k++)
      if (p == (CNT_W'(1) << (k + 1))) c = DIV_WIDTH'(k);
    return c;
  endfunction

  logic               s1, s2, prev;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cand;
  logic [MATCH_W-1:0] match;
  state_t             state;

  logic               rise;
  logic               p_legal;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [MATCH_W-1:0] match_inc;
  logic               overdue;

  always_comb begin
    rise      = s2 & ~prev;
    p_legal   = is_legal(cnt);
    match_inc = match + 1'b1;
    if (rise)                cnt_nxt = CNT_W'(1);
    else if (cnt == CNT_MAX) cnt_nxt = cnt;
    else                     cnt_nxt = cnt + CNT_W'(1);
    // Overdue is flagged on the edge that would move cnt past the locked
    // period, so err lands together with cnt reaching cand+1.
    overdue   = ~rise && (cnt_nxt == cand + CNT_W'(1));
  end

  assign period = cand;

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      prev     <= 1'b0;
      cnt      <= '0;
      cand     <= '0;
      match    <= '0;
      state    <= IDLE;
      div_code <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else begin
      // synchronizer -> edge history -> period counter
      s1   <= clk_div_in;
      s2   <= s1;
      prev <= s2;
      cnt  <= cnt_nxt;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          // first edge only starts the measurement window
          if (rise) begin
            state <= MEASURE;
            match <= '0;
          end
        end
        MEASURE: begin
          if (rise) begin
            if (p_legal && (cnt == cand)) begin
              match <= match_inc;
              if (match_inc == MATCH_LAST) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              cand  <= p_legal ? cnt : '0;
              match <= '0;
              if (p_legal) div_code <= code_of(cnt);
            end
          end else if (cnt == CNT_MAX) begin
            state <= IDLE;
            match <= '0;
          end
        end
        LOCKED: begin
          if (rise) begin
            if (cnt != cand) begin
              err    <= 1'b1;
              locked <= 1'b0;
              state  <= MEASURE;
              cand   <= p_legal ? cnt : '0;
              match  <= '0;
              if (p_legal) div_code <= code_of(cnt);
            end
          end else if (overdue) begin
            err    <= 1'b1;
            locked <= 1'b0;
            state  <= MEASURE;
            match  <= '0;
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/clk_div_detector.md
# clk_div_detector

Frequency-ratio detector for the divided clocks produced by the DFF ripple divider. It samples a divided clock in the `clk_in` domain and measures its period in `clk_in` cycles. It decodes the period back to the `div_ctrl` code that produced it (period = 2^(k+1)) and reports lock once the ratio is stable. It sits beside the divider as its monitor/decoder, for self-check and for downstream logic that must know the active ratio.

## Interface
- `DIV_WIDTH`, 2: width of the decoded code. Legal codes k = 0..DIV_WIDTH-1, i.e. periods 2..2^DIV_WIDTH.
- `LOCK_COUNT`, 4: consecutive identical legal periods required for lock. Must be ≥ 2.
- Derived, not overridable: `CNT_W` = DIV_WIDTH+2, the period counter width.

Ports:
- `clk_in`  input  1  reference (undivided) clock; all logic on its rising edge.
- `rstn`  input  1  asynchronous, active-low reset.
- `clk_div_in`  input  1  divided clock under measurement; treated as asynchronous.
- `div_code`  output  DIV_WIDTH  decoded k of the locked period.
- `period`  output  CNT_W  candidate period in `clk_in` cycles.
- `locked`  output  1  ratio stable.
- `err`  output  1  one-cycle pulse on loss of lock.

## Operation
- Input path:
  - 2-FF synchronizer `s1`→`s2`, then history register `prev`.
  - `rise` = s2 & ~prev, combinational.
  - `s1`, `s2` and `prev` all reset to 0.
- Period counter `cnt` (CNT_W bits, reset 0):
  - Loads 1 on a cycle with `rise`.
  - Otherwise increments, saturating at 2^CNT_W-1.
  - At a `rise`, `cnt` equals the cycles since the previous `rise` (measured period P).
- P is legal iff P = 2^(k+1) for some k in 0..DIV_WIDTH-1. Saturated `cnt` is never legal.
- Internal registers: `cand` (CNT_W) and `match` (counts 0..LOCK_COUNT-1).
- FSM states IDLE, MEASURE, LOCKED (reset IDLE):
  - IDLE, on `rise`: go to MEASURE, `match` ← 0, no measurement taken.
  - MEASURE, on `rise` with P legal and P == `cand`: `match` ← `match`+1. If `match`+1 == LOCK_COUNT-1, go to LOCKED.
  - MEASURE, on `rise` otherwise: `cand` ← P if P is legal, else 0. `match` ← 0.
  - MEASURE, `cnt` saturated: go to IDLE, `match` ← 0.
  - LOCKED, on `rise` with P == `cand`: stay.
  - LOCKED, on `rise` with P ≠ `cand`: `err` pulse. Go to MEASURE, `cand` ← P if legal else 0, `match` ← 0.
  - LOCKED, no `rise` and `cnt` == `cand`+1 (edge overdue): `err` pulse, go to MEASURE, `match` ← 0.
- Outputs:
  - `locked` = (state == LOCKED), registered.
  - `period` = `cand`.
  - `div_code` = log2(`cand`)-1 while `cand` is legal. It is held from the last legal value otherwise and is meaningful only when `locked`=1.
  - `err` is never asserted outside the LOCKED→MEASURE transitions.
- Reset mid-operation: all registers clear immediately. No `err` is issued.

## Timing
- All outputs are registered.
- Reset values: `div_code`=0, `period`=0, `locked`=0, `err`=0.
- `clk_div_in` rising edge to `rise`: asserted in the cycle after the 2nd `clk_in` edge sampling it high (2-cycle synchronizer latency + edge detect).
- Lock latency: LOCK_COUNT+1 `rise` pulses from IDLE, all with equal legal spacing. `locked`, `period` and `div_code` update on the `clk_in` edge at which the final `rise` is sampled.
- Unlock, mismatch case: `err`=1 and `locked`=0 on the same edge that samples the mismatching `rise`.
- Unlock, timeout case: `err`=1 and `locked`=0 on the same edge that sets `cnt` to `cand`+1.
- Period 2 (k=0) is supported: `clk_div_in` toggles every `clk_in` cycle and must change only after the `clk_in` rising edge.

## Test plan
DIV_WIDTH=3, LOCK_COUNT=4, `clk_div_in` driven from an actual ripple divider or updated on `clk_in` negedges.

1. Reset: hold `rstn`=0 with `clk_div_in` toggling → `div_code`=0, `period`=0, `locked`=0, `err`=0 throughout.
2. Period 8: release reset, drive period 8 → `locked`=1 exactly at the 5th `rise`, with `div_code`=2, `period`=8. `err` never pulses.
3. Ratio change while locked: switch period 8 → 4 → one-cycle `err` and `locked`=0 at the first short `rise`. Relock after 3 further period-4 rises with `div_code`=1, `period`=4.
4. Clock stop while locked at period 2: hold `clk_div_in` low → `err` pulses and `locked` drops when `cnt`=3. State reaches IDLE when `cnt` saturates at 31. No further `err`.
5. Illegal period 6: drive period 6 indefinitely → `locked` stays 0, `err` stays 0, `period`=0.
6. Reset mid-lock: locked at period 4, pulse `rstn` low mid-cycle → all outputs 0 asynchronously with no `err`. After release, relock on the 5th `rise` with `div_code`=1.
